// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a debounced lock with timeout
// and retries, then releases the downstream system reset while lock holds.
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state_o
);

    localparam int unsigned MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_P = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    localparam logic [2:0] RESET_PLL = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABLE    = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] FAILED    = 3'd4;

    logic             lk_meta_q;
    logic             lk_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;

    // pll_locked comes from the PLL's own timing; two flops before any decision uses it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_q      <= lk_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (restart_req) begin
            state_d = RESET_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // Lock seen on the timeout cycle takes precedence over the retry
                    if (lk_q) begin
                        state_d = STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = (retry_q >= RETRY_MAX) ? RETRY_MAX : retry_q + 4'd1;
                        state_d = (retry_d == RETRY_MAX) ? FAILED : RESET_PLL;
                    end
                end
                STABLE: begin
                    if (!lk_q) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!lk_q) begin
                        state_d = RESET_PLL;
                        retry_d = '0;
                    end
                end
                FAILED: begin
                    state_d = FAILED;
                end
                default: begin
                    state_d = RESET_PLL;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Counter only runs in the timed states; RUN and FAILED just hold it
    always_comb begin
        if (restart_req || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == RUN) || (state_q == FAILED)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst   <= (state_d == RESET_PLL) || (state_d == FAILED);
            sys_rst_n <= (state_d == RUN);
            ready     <= (state_d == RUN);
            fail      <= (state_d == FAILED);
        end
    end

    assign retry_cnt = retry_q;
    assign state_o   = state_q;

endmodule
